// File: rtl/wasm_stack_core.sv
// ---------------------------------------------------------------------------
// wasm_stack_core
//   Single-issue WASM fetch/execute core. The operand stack and the call
//   stack live in internal register arrays, so the byte-wide memory port is
//   used only for opcode and immediate fetch. Immediates are signed/unsigned
//   LEB128. Calls resolve their target through an external combinational
//   function table.
//
// Ports
//   clk, rst_n        clock (rising edge), async active-low reset
//   start, start_pc   one-cycle start pulse and entry address (idle states only)
//   mem_addr          byte read address (the pc)
//   mem_rd_en         read request, held with a stable address until mem_ready
//   mem_rdata         read data, valid with mem_ready
//   mem_ready         one-cycle read completion
//   func_idx          function index (driven by call in EXEC, held otherwise)
//   func_addr         combinational function-table result for func_idx
//   busy/halted/trapped  status; trap_code gives the trap reason
//   tos, sp           top of operand stack (0 when empty) and its occupancy
// ---------------------------------------------------------------------------
module wasm_stack_core #(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 32,
    parameter int OP_DEPTH   = 16,
    parameter int CALL_DEPTH = 8,
    parameter int FIDX_W     = 8
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            start,
    input  logic [ADDR_W-1:0]               start_pc,
    output logic [ADDR_W-1:0]               mem_addr,
    output logic                            mem_rd_en,
    input  logic [7:0]                      mem_rdata,
    input  logic                            mem_ready,
    output logic [FIDX_W-1:0]               func_idx,
    input  logic [ADDR_W-1:0]               func_addr,
    output logic                            busy,
    output logic                            halted,
    output logic                            trapped,
    output logic [2:0]                      trap_code,
    output logic [DATA_W-1:0]               tos,
    output logic [$clog2(OP_DEPTH+1)-1:0]   sp
);

    localparam int SP_W  = $clog2(OP_DEPTH + 1);
    localparam int OPI_W = $clog2(OP_DEPTH);
    localparam int CSP_W = $clog2(CALL_DEPTH + 1);
    localparam int CSI_W = $clog2(CALL_DEPTH);

    localparam logic [SP_W-1:0]  SP_FULL = SP_W'(OP_DEPTH);
    localparam logic [CSP_W-1:0] CS_FULL = CSP_W'(CALL_DEPTH);

    localparam logic [7:0] OP_UNREACH = 8'h00;
    localparam logic [7:0] OP_NOP     = 8'h01;
    localparam logic [7:0] OP_END     = 8'h0B;
    localparam logic [7:0] OP_CALL    = 8'h10;
    localparam logic [7:0] OP_DROP    = 8'h1A;
    localparam logic [7:0] OP_LGET    = 8'h20;
    localparam logic [7:0] OP_LSET    = 8'h21;
    localparam logic [7:0] OP_CONST   = 8'h41;
    localparam logic [7:0] OP_ADD     = 8'h6A;
    localparam logic [7:0] OP_SUB     = 8'h6B;
    localparam logic [7:0] OP_MUL     = 8'h6C;

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_IMM, S_EXEC, S_HALT, S_TRAP
    } state_t;

    state_t              state, state_nx;
    logic [2:0]          trap_nx;

    logic                rd_en;
    logic [ADDR_W-1:0]   pc;
    logic [7:0]          opcode;
    logic [31:0]         imm, imm_nx;
    logic [2:0]          imm_cnt;
    logic [CSP_W-1:0]    csp;
    logic [FIDX_W-1:0]   fidx_q;

    logic [DATA_W-1:0]   ops  [OP_DEPTH];
    logic [ADDR_W-1:0]   cstk [CALL_DEPTH];

    logic                byte_ok, idle_like, accept;
    logic                has_imm_b, plain_b;
    logic                sp_lt2, cs_empty, exec_ok;
    logic [SP_W-1:0]     sp_m1, sp_m2;
    logic [CSP_W-1:0]    csp_m1;
    logic [31:0]         alu_a, alu_b, alu_r;
    logic                push_we, alu_we, call_we;

    assign mem_addr  = pc;
    assign mem_rd_en = rd_en;

    // A byte is consumed only while a request is outstanding.
    assign byte_ok   = rd_en & mem_ready;
    assign idle_like = (state == S_IDLE) | (state == S_HALT) | (state == S_TRAP);
    assign accept    = idle_like & start;

    assign has_imm_b = (mem_rdata == OP_CALL) | (mem_rdata == OP_CONST) |
                       (mem_rdata == OP_LGET) | (mem_rdata == OP_LSET);
    assign plain_b   = (mem_rdata == OP_UNREACH) | (mem_rdata == OP_NOP) |
                       (mem_rdata == OP_DROP) | (mem_rdata == OP_ADD) |
                       (mem_rdata == OP_SUB) | (mem_rdata == OP_MUL) |
                       (mem_rdata == OP_END);

    assign sp_m1    = sp - SP_W'(1);
    assign sp_m2    = sp - SP_W'(2);
    assign csp_m1   = csp - CSP_W'(1);
    assign sp_lt2   = sp < SP_W'(2);
    assign cs_empty = csp == '0;

    assign tos = (sp == '0) ? '0 : ops[sp_m1[OPI_W-1:0]];

    // LEB128 accumulation. For i32.const the final byte's bit 6 is the sign;
    // a full five-byte encoding already covers all 32 bits, so no fill there.
    always_comb begin
        imm_nx = imm | ({25'd0, mem_rdata[6:0]} << ({29'd0, imm_cnt} * 32'd7));
        if (opcode == OP_CONST && !mem_rdata[7] && mem_rdata[6] && imm_cnt < 3'd4)
            imm_nx = imm_nx | (32'hFFFF_FFFF << (({29'd0, imm_cnt} + 32'd1) * 32'd7));
    end

    // i32 ALU: a is the second entry, b the top.
    assign alu_a = ops[sp_m2[OPI_W-1:0]][31:0];
    assign alu_b = tos[31:0];
    always_comb begin
        case (opcode)
            OP_SUB:  alu_r = alu_a - alu_b;
            OP_MUL:  alu_r = alu_a * alu_b;
            default: alu_r = alu_a + alu_b;
        endcase
    end

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nx;
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_nx = state;
        trap_nx  = 3'd0;
        case (state)
            S_IDLE, S_HALT, S_TRAP: if (start) state_nx = S_FETCH;
            S_FETCH: if (byte_ok) begin
                if (has_imm_b)    state_nx = S_IMM;
                else if (plain_b) state_nx = S_EXEC;
                else begin        state_nx = S_TRAP; trap_nx = 3'd5; end
            end
            S_IMM: if (byte_ok) begin
                if (!mem_rdata[7])        state_nx = S_EXEC;
                else if (imm_cnt == 3'd4) begin state_nx = S_TRAP; trap_nx = 3'd6; end
            end
            S_EXEC: begin
                state_nx = S_FETCH;
                case (opcode)
                    OP_UNREACH: begin state_nx = S_TRAP; trap_nx = 3'd1; end
                    OP_CONST:   if (sp == SP_FULL) begin state_nx = S_TRAP; trap_nx = 3'd2; end
                    OP_DROP:    if (sp == '0) begin state_nx = S_TRAP; trap_nx = 3'd3; end
                    OP_ADD, OP_SUB, OP_MUL:
                                if (sp_lt2) begin state_nx = S_TRAP; trap_nx = 3'd3; end
                    OP_CALL:    if (csp == CS_FULL) begin state_nx = S_TRAP; trap_nx = 3'd4; end
                    OP_END:     if (cs_empty) state_nx = S_HALT;
                    OP_LGET, OP_LSET: begin state_nx = S_TRAP; trap_nx = 3'd5; end
                    default: ;
                endcase
            end
            default: state_nx = S_IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        busy     = !idle_like;
        halted   = state == S_HALT;
        trapped  = state == S_TRAP;
        func_idx = fidx_q;
        if (state == S_EXEC && opcode == OP_CALL) func_idx = imm[FIDX_W-1:0];
    end

    // EXEC that does not trap commits its stack/pc effects.
    assign exec_ok = (state == S_EXEC) && (state_nx != S_TRAP);
    assign push_we = exec_ok && opcode == OP_CONST;
    assign alu_we  = exec_ok && (opcode == OP_ADD || opcode == OP_SUB || opcode == OP_MUL);
    assign call_we = exec_ok && opcode == OP_CALL;

    // ---------------- datapath / control registers ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_en     <= 1'b0;
            pc        <= '0;
            opcode    <= '0;
            imm       <= '0;
            imm_cnt   <= '0;
            sp        <= '0;
            csp       <= '0;
            trap_code <= '0;
            fidx_q    <= '0;
        end else begin
            fidx_q <= func_idx;
            if (accept) begin
                pc        <= start_pc;
                sp        <= '0;
                csp       <= '0;
                trap_code <= '0;
                rd_en     <= 1'b0;
            end
            if (state_nx == S_TRAP && state != S_TRAP) trap_code <= trap_nx;
            case (state)
                S_FETCH, S_IMM: begin
                    if (byte_ok) begin
                        // The byte is consumed even when it leads to a trap.
                        rd_en <= 1'b0;
                        pc    <= pc + ADDR_W'(1);
                        if (state == S_FETCH) begin
                            opcode  <= mem_rdata;
                            imm     <= '0;
                            imm_cnt <= '0;
                        end else begin
                            imm     <= imm_nx;
                            imm_cnt <= imm_cnt + 3'd1;
                        end
                    end else if (!rd_en) begin
                        rd_en <= 1'b1;
                    end
                end
                S_EXEC: if (exec_ok) begin
                    case (opcode)
                        OP_CONST: sp <= sp + SP_W'(1);
                        OP_DROP, OP_ADD, OP_SUB, OP_MUL: sp <= sp_m1;
                        OP_CALL: begin
                            csp <= csp + CSP_W'(1);
                            pc  <= func_addr;
                        end
                        OP_END: if (!cs_empty) begin
                            csp <= csp_m1;
                            pc  <= cstk[csp_m1[CSI_W-1:0]];
                        end
                        default: ;
                    endcase
                end
                default: ;
            endcase
        end
    end

    // Stack storage needs no reset: occupancy counters define validity.
    always_ff @(posedge clk) begin
        if (push_we) ops[sp[OPI_W-1:0]]    <= DATA_W'(imm);
        if (alu_we)  ops[sp_m2[OPI_W-1:0]] <= DATA_W'(alu_r);
        if (call_we) cstk[csp[CSI_W-1:0]]  <= pc;
    end

endmodule

// File: tb/tb_wasm_stack_core.sv
module tb_wasm_stack_core;

    localparam int OPD = 16;
    localparam int CSD = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [31:0] start_pc = '0;
    logic [31:0] mem_addr;
    logic        mem_rd_en;
    logic [7:0]  mem_rdata = '0;
    logic        mem_ready = 1'b0;
    logic [7:0]  func_idx;
    logic [31:0] func_addr;
    logic        busy, halted, trapped;
    logic [2:0]  trap_code;
    logic [31:0] tos;
    logic [4:0]  sp;

    logic [7:0]  mem  [256];
    logic [31:0] ftab [256];

    int n_chk = 0;
    int n_err = 0;
    int max_lat = 0;
    int wcnt = 0;
    int pos = 0;

    wasm_stack_core dut (
        .clk(clk), .rst_n(rst_n), .start(start), .start_pc(start_pc),
        .mem_addr(mem_addr), .mem_rd_en(mem_rd_en), .mem_rdata(mem_rdata),
        .mem_ready(mem_ready), .func_idx(func_idx), .func_addr(func_addr),
        .busy(busy), .halted(halted), .trapped(trapped), .trap_code(trap_code),
        .tos(tos), .sp(sp)
    );

    assign func_addr = ftab[func_idx];

    always #5 clk = ~clk;

    // Byte memory responder with random latency; one-cycle mem_ready pulses.
    initial forever begin
        @(posedge clk); #1;
        if (!rst_n) begin
            mem_ready = 1'b0; wcnt = 0;
        end else if (mem_ready) begin
            mem_ready = 1'b0;
        end else if (mem_rd_en) begin
            if (wcnt == 0) begin
                mem_ready = 1'b1;
                mem_rdata = mem[mem_addr[7:0]];
                wcnt = $urandom_range(max_lat, 0);
            end else wcnt--;
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 256; i++) begin mem[i] = 8'h00; ftab[i] = 32'h0; end
        pos = 0;
    endtask

    task automatic put(input logic [7:0] b);
        mem[pos & 255] = b; pos++;
    endtask

    task automatic put_bytes(input int base, input logic [7:0] q[$]);
        pos = base;
        foreach (q[i]) put(q[i]);
    endtask

    // Minimal signed LEB128 encoding of a 32-bit value.
    task automatic put_sleb(input int v);
        logic [7:0] b;
        bit done;
        do begin
            b = 8'(v & 32'h7F);
            v = v >>> 7;
            done = (v == 0 && !b[6]) || (v == -1 && b[6]);
            if (!done) b[7] = 1'b1;
            put(b);
        end while (!done);
    endtask

    // Reference interpreter: walks the program bytes directly.
    // st: 1 = halted, 2 = trapped.
    task automatic model(input int pc0, output int st, output int code,
                         output int esp, output logic [31:0] etos);
        logic [31:0] q[$];
        int cs[$];
        int pc, n;
        logic [7:0] op, b;
        longint v;
        logic [31:0] imm, a, bb;
        pc = pc0; st = 0; code = 0;
        for (int step = 0; step < 5000 && st == 0; step++) begin
            op = mem[pc & 255]; pc++;
            imm = '0;
            if (op == 8'h10 || op == 8'h41 || op == 8'h20 || op == 8'h21) begin
                v = 0; n = 0;
                forever begin
                    b = mem[pc & 255]; pc++;
                    v = v | (longint'(b & 8'h7F) << (7 * n));
                    if (b[7]) begin
                        if (n == 4) begin st = 2; code = 6; break; end
                        n++;
                    end else begin
                        if (op == 8'h41 && b[6]) v = v - (longint'(1) << (7 * (n + 1)));
                        break;
                    end
                end
                if (st != 0) break;
                imm = v[31:0];
            end
            case (op)
                8'h00: begin st = 2; code = 1; end
                8'h01: ;
                8'h41: if (q.size() == OPD) begin st = 2; code = 2; end else q.push_back(imm);
                8'h1A: if (q.size() == 0) begin st = 2; code = 3; end else void'(q.pop_back());
                8'h6A, 8'h6B, 8'h6C:
                    if (q.size() < 2) begin st = 2; code = 3; end
                    else begin
                        bb = q.pop_back(); a = q.pop_back();
                        q.push_back(op == 8'h6A ? a + bb : op == 8'h6B ? a - bb : a * bb);
                    end
                8'h10: if (cs.size() == CSD) begin st = 2; code = 4; end
                       else begin cs.push_back(pc); pc = int'(ftab[imm[7:0]]); end
                8'h0B: if (cs.size() == 0) st = 1; else pc = cs.pop_back();
                default: begin st = 2; code = 5; end
            endcase
        end
        esp  = q.size();
        etos = (q.size() == 0) ? 32'h0 : q[q.size() - 1];
    endtask

    task automatic run(input string tag, input int pc0);
        int st, code, esp, cyc;
        logic [31:0] etos;
        @(negedge clk); start = 1'b1; start_pc = pc0;
        @(negedge clk); start = 1'b0;
        cyc = 0;
        while (!(halted || trapped) && cyc < 6000) begin @(negedge clk); cyc++; end
        if (cyc >= 6000) chk({tag, "_timeout"}, 1, 0);
        model(pc0, st, code, esp, etos);
        chk({tag, "_halted"},  halted,    st == 1);
        chk({tag, "_trapped"}, trapped,   st == 2);
        chk({tag, "_code"},    trap_code, code);
        chk({tag, "_sp"},      sp,        esp);
        chk({tag, "_tos"},     tos,       etos);
        chk({tag, "_busy"},    busy,      0);
    endtask

    task automatic gen_rand();
        int n, r;
        clear_mem();
        ftab[2] = 32'hC0;
        put_bytes(32'hC0, '{8'h41, 8'h09, 8'h6C, 8'h0B});
        pos = 0;
        n = $urandom_range(14, 1);
        for (int i = 0; i < n; i++) begin
            r = $urandom_range(13, 0);
            case (r)
                0, 1:    begin put(8'h41); put_sleb(int'($urandom_range(63, 0)) - 32); end
                2:       begin put(8'h41); put_sleb(int'($urandom)); end
                3, 4:    begin put(8'h41); put_sleb(int'($urandom_range(100000, 0)) - 50000); end
                5:       put(8'h6A);
                6:       put(8'h6B);
                7:       put(8'h6C);
                8:       put(8'h1A);
                9:       put(8'h01);
                10, 11:  begin put(8'h10); put(8'h02); end
                12:      put(($urandom_range(3, 0) == 0) ? 8'hFF : 8'h01);
                default: begin put(8'h41); put(8'h80); put(8'h01); end
            endcase
        end
        put(8'h0B);
    endtask

    initial begin
        int cyc;
        clear_mem();
        repeat (3) @(negedge clk);
        chk("rst_rd_en",   mem_rd_en, 0);
        chk("rst_addr",    mem_addr,  0);
        chk("rst_busy",    busy,      0);
        chk("rst_halted",  halted,    0);
        chk("rst_trapped", trapped,   0);
        chk("rst_code",    trap_code, 0);
        chk("rst_sp",      sp,        0);
        chk("rst_tos",     tos,       0);
        chk("rst_fidx",    func_idx,  0);
        rst_n = 1'b1;

        // Add program, minimal latency.
        put_bytes(0, '{8'h41, 8'h05, 8'h41, 8'h07, 8'h6A, 8'h0B});
        run("add", 0);
        chk("add_tos12", tos, 12);

        max_lat = 2;
        clear_mem(); put_bytes(0, '{8'h41, 8'h7F, 8'h0B});
        run("neg1", 0);  chk("neg1_val", tos, 32'hFFFF_FFFF);
        clear_mem(); put_bytes(0, '{8'h41, 8'hE5, 8'h8E, 8'h26, 8'h0B});
        run("leb3", 0);  chk("leb3_val", tos, 624485);
        clear_mem(); put_bytes(0, '{8'h41, 8'h0A, 8'h41, 8'h03, 8'h6B, 8'h41, 8'h04, 8'h6C, 8'h0B});
        run("submul", 0); chk("submul_val", tos, 28);

        clear_mem(); for (int i = 0; i < OPD + 1; i++) begin put(8'h41); put(8'(i)); end put(8'h0B);
        run("ovf", 0);   chk("ovf_code", trap_code, 2); chk("ovf_sp", sp, OPD);
        clear_mem(); put_bytes(0, '{8'h6A});
        run("unf", 0);   chk("unf_code", trap_code, 3);

        clear_mem(); ftab[5] = 32'h20;
        put_bytes(0, '{8'h10, 8'h05, 8'h0B}); put_bytes(32'h20, '{8'h41, 8'h03, 8'h0B});
        run("call", 0);  chk("call_tos", tos, 3); chk("call_fidx", func_idx, 5);
        clear_mem(); ftab[1] = 32'h40;
        put_bytes(0, '{8'h10, 8'h01}); put_bytes(32'h40, '{8'h10, 8'h01});
        run("cdeep", 0); chk("cdeep_code", trap_code, 4);

        clear_mem(); put_bytes(0, '{8'h41, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80});
        run("leblong", 0); chk("leblong_code", trap_code, 6);
        clear_mem(); put_bytes(0, '{8'h41, 8'h01, 8'hFF});
        run("illegal", 0); chk("illegal_code", trap_code, 5);
        clear_mem(); put_bytes(0, '{8'h20, 8'h00});
        run("lget", 0);
        clear_mem(); put_bytes(0, '{8'h00});
        run("unreach", 0); chk("unreach_code", trap_code, 1);

        // Randomized programs at random latencies.
        for (int t = 0; t < 30; t++) begin
            max_lat = $urandom_range(3, 0);
            gen_rand();
            run($sformatf("rnd%0d", t), 0);
        end

        // Reset while an immediate byte is being requested.
        max_lat = 2;
        clear_mem(); put_bytes(0, '{8'h41, 8'hE5, 8'h8E, 8'h26, 8'h0B});
        @(negedge clk); start = 1'b1; start_pc = 0;
        @(negedge clk); start = 1'b0;
        cyc = 0;
        while (!(mem_rd_en && mem_addr == 1) && cyc < 100) begin @(negedge clk); cyc++; end
        if (cyc >= 100) chk("midrst_wait", 1, 0);
        #1 rst_n = 1'b0;
        #1;
        chk("midrst_rd_en", mem_rd_en, 0);
        chk("midrst_busy",  busy,      0);
        chk("midrst_sp",    sp,        0);
        chk("midrst_addr",  mem_addr,  0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        run("rerun", 0); chk("rerun_val", tos, 624485);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
